// File: rtl/jk_seq_driver.sv
// -----------------------------------------------------------------------------
// jk_seq_driver
//
// Stimulus end of a j/k/q interface to an external JK flip-flop. A target bit
// pattern is loaded through a valid/ready port. On start, the block computes
// the JK excitation that steers the flop's q through the pattern, one bit per
// clock. Two cycles after each bit is issued, the block checks the flop's
// returned q against that bit. It reports failures through a sticky mismatch
// flag and a saturating error count.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   load_valid  pattern load request
//   load_ready  high while idle (combinational from state)
//   load_data   target bits, bit 0 driven first
//   load_len    number of bits to drive; values above DEPTH clamp to DEPTH
//   start       begin driving the stored pattern (idle only, not with a load)
//   j, k        registered excitation to the flop
//   q_fb        flop q output
//   busy        high while driving or draining the compare pipeline
//   done        one-cycle pulse at the end of a run
//   mismatch    sticky compare-failure flag for the current run
//   err_count   saturating count of compare failures in the current run
// -----------------------------------------------------------------------------
module jk_seq_driver #(
    parameter int DEPTH       = 8,
    parameter bit TOGGLE_PREF = 1'b0,
    parameter int CNT_W       = 4,
    localparam int LEN_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [DEPTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic             start,
    output logic             j,
    output logic             k,
    input  logic             q_fb,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DEPTH-1:0]   pat_q, pat_d;     // stored pattern, kept for re-runs
    logic [DEPTH-1:0]   work_q, work_d;   // shifting copy consumed while driving
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   rem_q, rem_d;     // bits still to issue
    logic               cur_q, cur_d;     // expected flop state after last issue
    logic               j_q, j_d;
    logic               k_q, k_d;
    logic               done_q, done_d;
    logic               mm_q, mm_d;
    logic [CNT_W-1:0]   err_q, err_d;
    // Expect pipeline: stage 0 holds the bit issued at the last edge, stage 1
    // the bit whose effect on q is visible now.
    logic               s0_vld_q, s0_vld_d, s0_bit_q, s0_bit_d;
    logic               s1_vld_q, s1_vld_d, s1_bit_q, s1_bit_d;

    logic               load_fire;
    logic               start_fire;
    logic [LEN_W-1:0]   len_clamped;
    logic               t_bit;

    assign load_ready  = (state_q == ST_IDLE);
    assign load_fire   = load_valid && load_ready;
    assign start_fire  = start && load_ready && !load_fire;
    assign len_clamped = (load_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : load_len;
    assign t_bit       = work_q[0];

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        work_d   = work_q;
        len_d    = len_q;
        rem_d    = rem_q;
        cur_d    = cur_q;
        j_d      = 1'b0;
        k_d      = 1'b0;
        done_d   = 1'b0;
        mm_d     = mm_q;
        err_d    = err_q;
        s1_vld_d = s0_vld_q;
        s1_bit_d = s0_bit_q;
        s0_vld_d = 1'b0;
        s0_bit_d = 1'b0;

        // The compare runs in every state; the pipeline is empty when idle.
        if (s1_vld_q && (q_fb != s1_bit_q)) begin
            mm_d = 1'b1;
            if (err_q != '1) begin
                err_d = err_q + CNT_W'(1);
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (load_fire) begin
                    pat_d = load_data;
                    len_d = len_clamped;
                end else if (start_fire) begin
                    // The only point where q_fb seeds the expected state.
                    cur_d  = q_fb;
                    work_d = pat_q;
                    rem_d  = len_q;
                    mm_d   = 1'b0;
                    err_d  = '0;
                    if (len_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (cur_q != t_bit) begin
                    if (TOGGLE_PREF) begin
                        j_d = 1'b1;
                        k_d = 1'b1;
                    end else begin
                        j_d = t_bit;
                        k_d = ~t_bit;
                    end
                end
                cur_d    = t_bit;
                work_d   = work_q >> 1;
                rem_d    = rem_q - LEN_W'(1);
                s0_vld_d = 1'b1;
                s0_bit_d = t_bit;
                if (rem_q == LEN_W'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Stage 0 empty means stage 1 holds the final bit being
                // compared at this edge.
                if (!s0_vld_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pat_q    <= '0;
            work_q   <= '0;
            len_q    <= '0;
            rem_q    <= '0;
            cur_q    <= 1'b0;
            j_q      <= 1'b0;
            k_q      <= 1'b0;
            done_q   <= 1'b0;
            mm_q     <= 1'b0;
            err_q    <= '0;
            s0_vld_q <= 1'b0;
            s0_bit_q <= 1'b0;
            s1_vld_q <= 1'b0;
            s1_bit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            work_q   <= work_d;
            len_q    <= len_d;
            rem_q    <= rem_d;
            cur_q    <= cur_d;
            j_q      <= j_d;
            k_q      <= k_d;
            done_q   <= done_d;
            mm_q     <= mm_d;
            err_q    <= err_d;
            s0_vld_q <= s0_vld_d;
            s0_bit_q <= s0_bit_d;
            s1_vld_q <= s1_vld_d;
            s1_bit_q <= s1_bit_d;
        end
    end

    assign j         = j_q;
    assign k         = k_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign mismatch  = mm_q;
    assign err_count = err_q;

endmodule

// File: doc/jk_seq_driver.md
Name: jk_seq_driver

Overview:
Driver for an external JK flip-flop: the stimulus end of the j/k/q interface.
- Accepts a target bit pattern (up to DEPTH bits) via a valid/ready load port.
- On start, computes the JK excitation that makes the flop's q follow the pattern, one bit per clock, and drives j/k.
- Checks the flop's returned q against the expected value two cycles later, and reports mismatches and a saturating error count.
- Used as a self-checking sequencer around jkff instances.

Parameters:
DEPTH, 8, max pattern length in bits (>=1)
TOGGLE_PREF, 0, 1 = use j=k=1 for every state change; 0 = use set (1,0) / reset (0,1)
CNT_W, 4, width of err_count

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
load_valid  input  1  pattern load request
load_ready  output  1  high when state==IDLE (combinational)
load_data  input  DEPTH  target bits; bit 0 driven first
load_len  input  $clog2(DEPTH+1)  number of bits to drive (0..DEPTH; larger values clamp to DEPTH)
start  input  1  begin driving the stored pattern
j  output  1  registered J to flop
k  output  1  registered K to flop
q_fb  input  1  flop q output
busy  output  1  high in DRIVE/DRAIN
done  output  1  one-cycle pulse at end of run
mismatch  output  1  sticky; set on any q_fb compare failure
err_count  output  CNT_W  saturating count of compare failures in current run

Behaviour:
- Reset (sync, rst=1 at edge):
  - State=IDLE.
  - j=k=0, busy=0, done=0, mismatch=0, err_count=0.
  - Pattern and length registers=0, pipeline valids=0.
  - Reset mid-run aborts immediately; no done pulse.
- Load: fires when load_valid && load_ready at an edge; latches load_data and the clamped load_len. Load is ignored outside IDLE.
- Start: accepted only in IDLE, at an edge where start=1 and no load fires.
  - A start coinciding with a load is ignored.
  - Start outside IDLE is ignored.
  - At the start edge (E0): cur←q_fb, idx←0, mismatch←0, err_count←0, then:
    - len==0: state stays IDLE, done=1 for the following cycle.
    - Otherwise: state←DRIVE.
- DRIVE: at each edge, with t=pattern[idx]:
  - Excitation (j,k) from (cur,t), registered:
    - 0→0: (0,0)
    - 1→1: (0,0)
    - 0→1: (1,0), or (1,1) if TOGGLE_PREF
    - 1→0: (0,1), or (1,1) if TOGGLE_PREF
  - cur←t; idx←idx+1.
  - Push t into a 2-stage expect pipeline with a valid bit.
  - After the edge issuing idx==len-1: state←DRAIN.
- DRAIN: j=k=0 (hold) from the first DRAIN edge. Remains until both pipeline stages are empty.
- Timing: bit i's j/k are visible after edge E0+1+i. The flop samples them at E0+2+i. The driver compares q_fb against bit i at edge E0+3+i.
- Compare: on mismatch, mismatch←1 and err_count←err_count+1, saturating at all-ones.
- End of run: the final compare occurs at edge E0+len+2. At that edge state←IDLE, busy←0, done←1 for exactly one cycle.
- busy=1 from after E0 until after the final-compare edge.
- Only cur tracks the expected state; q_fb is never used for excitation after E0, so a faulty flop cannot corrupt the sequence.
- mismatch and err_count hold their values in IDLE until the next accepted start or reset.

Test Plan:
- Reset check: hold rst 2 cycles mid-DRIVE → next cycle j=k=0, busy=0, done=0, mismatch=0, err_count=0, load_ready=1.
- Basic run (TOGGLE_PREF=0, flop q=0): load_data=8'b0000_1011, load_len=4, start.
  - j/k after E1..E4 = (1,0),(0,0),(0,1),(1,0).
  - q follows 1,1,0,1.
  - done pulses after E6; mismatch=0, err_count=0.
- Toggle preference (TOGGLE_PREF=1, same pattern) → j/k = (1,1),(0,0),(1,1),(1,1); q identical; no mismatch.
- Fault injection: force q_fb stuck at 0 during the basic run.
  - mismatch=1 from the E3 compare onward.
  - err_count=3 at done (bits 0, 1 and 3 differ).
- Boundaries: start with len=0 → done pulse next cycle, busy never set.
  - load_len=12 → clamped to 8, done at E0+10.
  - start with simultaneous load → start ignored.
  - start/load while busy → ignored.
- Saturation (CNT_W=2): 8-bit all-ones pattern with q_fb stuck at 0 → err_count=3, mismatch=1.
